// File: rtl/ldpc_enc_pkg.sv
// Shared types and helpers for the LDPC encoder control block.
// The package holds the FSM state encoding and the config range check.
package ldpc_enc_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENCODE  = 3'd1,
        S_HOLD    = 3'd2,
        S_PAR_OUT = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

    // A block length is usable only if it is nonzero and no larger than the hardware maximum.
    function automatic logic cfg_ok(input int unsigned val, input int unsigned max_val);
        return (val != 0) && (val <= max_val);
    endfunction

endpackage

// File: rtl/ldpc_beat_cnt.sv
// Beat counter with synchronous clear and enable.
// at_term_o flags the last beat of a block of length term_i.
module ldpc_beat_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         at_term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign at_term_o = (cnt_q == term_i - W'(1));

endmodule

// File: rtl/ldpc_enc_ctrl_p.sv
// Control FSM for the LDPC encoder datapath: generator load, info-beat accumulation
// and parity read-out, with run-time block lengths, handshakes and abort.
module ldpc_enc_ctrl_p
    import ldpc_enc_pkg::*;
#(
    parameter int MAX_INFO_BEATS = 64,
    parameter int MAX_PAR_BEATS  = 32,
    parameter int IW             = $clog2(MAX_INFO_BEATS + 1),
    parameter int PW             = $clog2(MAX_PAR_BEATS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [IW-1:0] cfg_info_beats,
    input  logic [PW-1:0] cfg_par_beats,
    input  logic          abort,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          read_parity,
    input  logic          par_ready,
    output logic          par_valid,
    output logic          par_last,
    output logic [PW-1:0] par_idx,
    output logic [IW-1:0] rom_addr,
    output logic          en_G,
    output logic          load_g,
    output logic          en_L,
    output logic          done_encode,
    output logic          rst_c,
    output logic          busy,
    output logic          cfg_err
);

    state_t        state_q, state_d;
    logic [IW-1:0] cfg_info_q;
    logic [PW-1:0] cfg_par_q;

    logic cfg_valid, start_acc;
    logic rom_clr, rom_en, rom_term;
    logic par_clr, par_en, par_term;

    assign cfg_valid = cfg_ok(32'(cfg_info_beats), MAX_INFO_BEATS)
                    && cfg_ok(32'(cfg_par_beats), MAX_PAR_BEATS);
    assign start_acc = (state_q == S_IDLE) && start && cfg_valid;

    // The final beat leaves the counter parked on the terminal value.
    assign rom_clr = start_acc || (state_q == S_CLEAR);
    assign rom_en  = (state_q == S_ENCODE) && din_valid && !abort && !rom_term;
    assign par_clr = ((state_q == S_HOLD) && read_parity && !abort) || (state_q == S_CLEAR);
    assign par_en  = (state_q == S_PAR_OUT) && par_ready && !abort && !par_term;

    ldpc_beat_cnt #(.W(IW)) u_rom_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (rom_clr),
        .en_i      (rom_en),
        .term_i    (cfg_info_q),
        .cnt_o     (rom_addr),
        .at_term_o (rom_term)
    );

    ldpc_beat_cnt #(.W(PW)) u_par_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (par_clr),
        .en_i      (par_en),
        .term_i    (cfg_par_q),
        .cnt_o     (par_idx),
        .at_term_o (par_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cfg_info_q <= '0;
            cfg_par_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                cfg_info_q <= cfg_info_beats;
                cfg_par_q  <= cfg_par_beats;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_acc) state_d = S_ENCODE;
            S_ENCODE:  if (abort) state_d = S_CLEAR;
                       else if (din_valid && rom_term) state_d = S_HOLD;
            S_HOLD:    if (abort) state_d = S_CLEAR;
                       else if (read_parity) state_d = S_PAR_OUT;
            S_PAR_OUT: if (abort) state_d = S_CLEAR;
                       else if (par_ready && par_term) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        din_ready   = 1'b0;
        en_L        = 1'b0;
        en_G        = 1'b0;
        load_g      = 1'b0;
        done_encode = 1'b0;
        par_valid   = 1'b0;
        par_last    = 1'b0;
        rst_c       = 1'b1;
        busy        = (state_q != S_IDLE);
        cfg_err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_g  = start_acc;
                en_G    = start_acc;
                cfg_err = start && !cfg_valid;
            end
            S_ENCODE: begin
                din_ready = !abort;
                en_L      = din_valid && !abort;
                en_G      = din_valid && !abort;
            end
            S_HOLD:    done_encode = 1'b1;
            S_PAR_OUT: begin
                par_valid = !abort;
                par_last  = !abort && par_term;
            end
            S_CLEAR:   rst_c = 1'b0;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_ldpc_enc_ctrl_p.sv
// Directed table-driven bench for ldpc_enc_ctrl_p, plus a max-config run with
// asynchronous reset during parity read-out.
module tb_ldpc_enc_ctrl_p;

    localparam int IW = 7;
    localparam int PW = 6;

    localparam logic [9:0] F_DR = 10'b1000000000;
    localparam logic [9:0] F_EL = 10'b0100000000;
    localparam logic [9:0] F_EG = 10'b0010000000;
    localparam logic [9:0] F_LG = 10'b0001000000;
    localparam logic [9:0] F_DN = 10'b0000100000;
    localparam logic [9:0] F_PV = 10'b0000010000;
    localparam logic [9:0] F_PL = 10'b0000001000;
    localparam logic [9:0] F_RC = 10'b0000000100;
    localparam logic [9:0] F_BZ = 10'b0000000010;
    localparam logic [9:0] F_CE = 10'b0000000001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, din_valid, read_parity, par_ready;
    logic [IW-1:0] cfg_info_beats;
    logic [PW-1:0] cfg_par_beats;
    logic          din_ready, par_valid, par_last, en_G, load_g, en_L;
    logic          done_encode, rst_c, busy, cfg_err;
    logic [PW-1:0] par_idx;
    logic [IW-1:0] rom_addr;

    ldpc_enc_ctrl_p dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_info_beats (cfg_info_beats),
        .cfg_par_beats  (cfg_par_beats),
        .abort          (abort),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .read_parity    (read_parity),
        .par_ready      (par_ready),
        .par_valid      (par_valid),
        .par_last       (par_last),
        .par_idx        (par_idx),
        .rom_addr       (rom_addr),
        .en_G           (en_G),
        .load_g         (load_g),
        .en_L           (en_L),
        .done_encode    (done_encode),
        .rst_c          (rst_c),
        .busy           (busy),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start, dv, rp, pr, ab;
        logic [IW-1:0] ci;
        logic [PW-1:0] cp;
        logic [22:0]   exp;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    wire [22:0] act = {din_ready, en_L, en_G, load_g, done_encode, par_valid, par_last,
                       rst_c, busy, cfg_err, rom_addr, par_idx};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, a, e);
    endtask

    function automatic void add(input logic s, input logic dv, input logic rp, input logic pr,
                                input logic ab, input int ci, input int cp,
                                input logic [9:0] f, input int rom, input int idx);
        vec_t v;
        v.start = s;  v.dv = dv; v.rp = rp; v.pr = pr; v.ab = ab;
        v.ci    = IW'(ci);
        v.cp    = PW'(cp);
        v.exp   = {f, IW'(rom), PW'(idx)};
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic s, input logic dv, input logic rp, input logic pr,
                         input logic ab, input int ci, input int cp);
        start = s; din_valid = dv; read_parity = rp; par_ready = pr; abort = ab;
        cfg_info_beats = IW'(ci);
        cfg_par_beats  = PW'(cp);
    endtask

    int el_cnt;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // info=4 par=2, continuous din_valid, then read-out with par_ready 1,0,1
        add(1,0,0,0,0, 4,2, F_EG|F_LG|F_RC,              0, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    0, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    1, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    2, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    3, 0);
        add(0,0,0,0,0, 0,0, F_DN|F_RC|F_BZ,              3, 0);
        add(0,0,1,0,0, 0,0, F_DN|F_RC|F_BZ,              3, 0);
        add(0,0,0,1,0, 0,0, F_PV|F_RC|F_BZ,              3, 0);
        add(0,0,0,0,0, 0,0, F_PV|F_PL|F_RC|F_BZ,         3, 1);
        add(0,0,0,1,0, 0,0, F_PV|F_PL|F_RC|F_BZ,         3, 1);
        add(1,0,0,0,0, 4,2, F_BZ,                        3, 1);
        add(0,0,0,0,0, 0,0, F_RC,                        0, 0);
        // gapped din_valid, read_parity ignored in S_ENCODE, abort from S_HOLD
        add(1,0,0,0,0, 4,2, F_EG|F_LG|F_RC,              0, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    0, 0);
        add(0,0,1,0,0, 0,0, F_DR|F_RC|F_BZ,              1, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    1, 0);
        add(0,0,0,0,0, 0,0, F_DR|F_RC|F_BZ,              2, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    2, 0);
        add(0,0,0,0,0, 0,0, F_DR|F_RC|F_BZ,              3, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    3, 0);
        add(0,0,0,0,1, 0,0, F_DN|F_RC|F_BZ,              3, 0);
        add(0,0,0,0,0, 0,0, F_BZ,                        3, 0);
        add(0,0,0,0,0, 0,0, F_RC,                        0, 0);
        // rejected configurations
        add(1,0,0,0,0, 0,2,  F_CE|F_RC,                  0, 0);
        add(0,0,0,0,0, 0,0,  F_RC,                       0, 0);
        add(1,0,0,0,0, 4,33, F_CE|F_RC,                  0, 0);
        add(1,0,0,0,0, 65,2, F_CE|F_RC,                  0, 0);
        add(0,0,0,0,0, 0,0,  F_RC,                       0, 0);
        // abort with din_valid after 2 of 8 beats, then a clean 1/1 codeword
        add(1,0,0,0,0, 8,2, F_EG|F_LG|F_RC,              0, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    0, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    1, 0);
        add(0,1,0,0,1, 0,0, F_RC|F_BZ,                   2, 0);
        add(0,0,0,0,0, 0,0, F_BZ,                        2, 0);
        add(0,0,0,0,0, 0,0, F_RC,                        0, 0);
        add(1,0,0,0,0, 1,1, F_EG|F_LG|F_RC,              0, 0);
        add(0,1,0,0,0, 0,0, F_DR|F_EL|F_EG|F_RC|F_BZ,    0, 0);
        add(0,0,1,0,0, 0,0, F_DN|F_RC|F_BZ,              0, 0);
        add(0,0,0,1,0, 0,0, F_PV|F_PL|F_RC|F_BZ,         0, 0);
        add(0,0,0,0,0, 0,0, F_BZ,                        0, 0);
        add(0,0,0,0,0, 0,0, F_RC,                        0, 0);

        #12;
        check("reset", 32'(act), 32'({F_RC, 7'd0, 6'd0}));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].dv, vecs[i].rp, vecs[i].pr, vecs[i].ab,
                  int'(vecs[i].ci), int'(vecs[i].cp));
            #4;
            check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
            @(posedge clk); #1;
        end

        // max config, async reset during parity read-out
        drive(1, 0, 0, 0, 0, 64, 32);
        #4 check("max_load", 32'({load_g, en_G}), 32'(2'b11));
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 0);
        el_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            #4 if (en_L) el_cnt++;
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #4;
        check("max_beats", 32'(el_cnt), 32'd64);
        check("max_rom",   32'(rom_addr), 32'd63);
        check("max_hold",  32'(done_encode), 32'd1);
        @(posedge clk); #1;
        drive(0, 0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
        end
        par_ready = 1'b0;
        #2 check("idx17", 32'({par_valid, par_idx}), 32'({1'b1, 6'd17}));
        rst_n = 1'b0;
        #1 check("async_rst", 32'(act), 32'({F_RC, 7'd0, 6'd0}));
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 4, 2);
        #4 check("post_rst_load", 32'({load_g, busy}), 32'(2'b10));
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 0);
        #4 check("post_rst_rom0", 32'({en_L, rom_addr}), 32'({1'b1, 7'd0}));
        @(posedge clk); #1;
        #4 check("post_rst_rom1", 32'(rom_addr), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
